// File: rtl/lcd_frame_pkg.sv
// Shared definitions for the LCD frame builder: word layout, character codes, FSM encoding.
// FRAME_DOUBLE_BUF_EN adds the SWAP state used by the double-buffered build.
package lcd_frame_pkg;

    localparam int unsigned WORD_W    = 11;
    localparam int unsigned RS_BIT    = 9;
    localparam int unsigned RW_BIT    = 8;
    localparam int unsigned FRAME_LEN = 11;
    localparam int unsigned IDX_W     = 4;

    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_STAR  = 8'h2A;
    localparam logic [7:0] CHAR_QMARK = 8'h3F;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

`ifdef FRAME_DOUBLE_BUF_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_WRITE = 2'd2,
        S_SWAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_WRITE = 2'd2
    } state_t;
`endif

    // RW is always 0 (write) and bit 10 reserved 0
    function automatic logic [WORD_W-1:0] make_word(input logic rs, input logic [7:0] db);
        logic [WORD_W-1:0] w;
        w         = '0;
        w[RS_BIT] = rs;
        w[RW_BIT] = 1'b0;
        w[7:0]    = db;
        return w;
    endfunction

    // Power-on frame: "00:00:00" with alarm off; entries past the frame read as 0
    function automatic logic [WORD_W-1:0] default_word(input int unsigned idx,
                                                       input logic [7:0] ddram);
        logic [WORD_W-1:0] w;
        case (idx)
            0:                  w = make_word(1'b0, ddram);
            1, 2, 4, 5, 7, 8:   w = make_word(1'b1, CHAR_ZERO);
            3, 6:               w = make_word(1'b1, CHAR_COLON);
            9, 10:              w = make_word(1'b1, CHAR_SPACE);
            default:            w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// One BCD digit to its ASCII character; non-decimal codes show as '?'.
module bcd_to_ascii
    import lcd_frame_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    assign ascii = (bcd <= 4'd9) ? (CHAR_ZERO + 8'(bcd)) : CHAR_QMARK;

endmodule

// File: rtl/lcd_frame_builder.sv
// Builds the 11-entry LCD command frame (DDRAM address + "HH:MM:SS" + alarm marker).
// FRAME_DOUBLE_BUF_EN selects two banks swapped on i_frame_done instead of in-place writes.
module lcd_frame_builder
    import lcd_frame_pkg::*;
#(
    parameter int unsigned WIDTH_MEM = 4,
    parameter logic [7:0]  DDRAM_POS = 8'h80
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_update,
    input  logic [7:0]           i_hours,
    input  logic [7:0]           i_minutes,
    input  logic [7:0]           i_seconds,
    input  logic                 i_alarm_on,
    input  logic                 i_frame_done,
    input  logic [WIDTH_MEM-1:0] i_rd_addr,
    output logic [WORD_W-1:0]    o_rd_command,
    output logic [WIDTH_MEM-1:0] o_addr_begin,
    output logic [WIDTH_MEM-1:0] o_addr_end,
    output logic                 o_busy
);

    localparam int unsigned DEPTH = 2 ** WIDTH_MEM;
`ifdef FRAME_DOUBLE_BUF_EN
    localparam int unsigned BANK_W = 1;
`else
    localparam int unsigned BANK_W = 0;
`endif
    localparam int unsigned MEM_AW    = WIDTH_MEM + BANK_W;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic               busy_d;
    logic               wr_en;
    logic               last_write;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         hours_q, minutes_q, seconds_q;
    logic               alarm_q;
    logic [WORD_W-1:0]  wr_word;
    logic [MEM_AW-1:0]  wr_addr, rd_addr;
    logic [WORD_W-1:0]  mem [MEM_DEPTH];
    logic [3:0]         digit [6];
    logic [7:0]         ascii [6];

    assign o_addr_begin = '0;
    assign o_addr_end   = WIDTH_MEM'(FRAME_LEN - 1);
    assign last_write   = (idx_q == IDX_W'(FRAME_LEN - 1));

    // Digit converters on the latched time, ordered as they appear on screen
    assign digit[0] = hours_q[7:4];
    assign digit[1] = hours_q[3:0];
    assign digit[2] = minutes_q[7:4];
    assign digit[3] = minutes_q[3:0];
    assign digit[4] = seconds_q[7:4];
    assign digit[5] = seconds_q[3:0];

    for (genvar g = 0; g < 6; g++) begin : g_digit
        bcd_to_ascii u_bcd_to_ascii (
            .bcd   (digit[g]),
            .ascii (ascii[g])
        );
    end

`ifdef FRAME_DOUBLE_BUF_EN
    logic active_q;
    logic swap_en;
    assign wr_addr = {~active_q, WIDTH_MEM'(idx_q)};
    assign rd_addr = {active_q, i_rd_addr};
`else
    logic frame_done_unused;
    assign frame_done_unused = i_frame_done;
    assign wr_addr = WIDTH_MEM'(idx_q);
    assign rd_addr = i_rd_addr;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state; any request while not idle folds into the single pending slot
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (state_q != S_IDLE && i_update) begin
            pending_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                pending_d = 1'b0;
                if (i_update || pending_q) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: state_d = S_WRITE;
            S_WRITE: begin
                if (last_write) begin
`ifdef FRAME_DOUBLE_BUF_EN
                    state_d = S_SWAP;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef FRAME_DOUBLE_BUF_EN
            S_SWAP: begin
                if (i_frame_done) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; busy stays up across a queued rebuild so there is no gap
    always_comb begin
        busy_d = (state_d != S_IDLE) || pending_d;
        wr_en  = (state_q == S_WRITE);
`ifdef FRAME_DOUBLE_BUF_EN
        swap_en = (state_q == S_SWAP) && i_frame_done;
`endif
    end

    // Character for the entry currently being written
    always_comb begin
        wr_word = '0;
        case (idx_q)
            4'd0:    wr_word = make_word(1'b0, DDRAM_POS);
            4'd1:    wr_word = make_word(1'b1, ascii[0]);
            4'd2:    wr_word = make_word(1'b1, ascii[1]);
            4'd3:    wr_word = make_word(1'b1, CHAR_COLON);
            4'd4:    wr_word = make_word(1'b1, ascii[2]);
            4'd5:    wr_word = make_word(1'b1, ascii[3]);
            4'd6:    wr_word = make_word(1'b1, CHAR_COLON);
            4'd7:    wr_word = make_word(1'b1, ascii[4]);
            4'd8:    wr_word = make_word(1'b1, ascii[5]);
            4'd9:    wr_word = make_word(1'b1, CHAR_SPACE);
            4'd10:   wr_word = make_word(1'b1, alarm_q ? CHAR_STAR : CHAR_SPACE);
            default: wr_word = '0;
        endcase
    end

    // Datapath: shadow time, write index, busy flag and frame storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q_reset();
        end else begin
            o_busy <= busy_d;
            if (state_q == S_LATCH) begin
                hours_q   <= i_hours;
                minutes_q <= i_minutes;
                seconds_q <= i_seconds;
                alarm_q   <= i_alarm_on;
                idx_q     <= '0;
            end else if (wr_en) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (wr_en) begin
                mem[wr_addr] <= wr_word;
            end
`ifdef FRAME_DOUBLE_BUF_EN
            if (swap_en) begin
                active_q <= ~active_q;
            end
`endif
        end
    end

    task automatic busy_q_reset();
        o_busy    <= 1'b0;
        hours_q   <= '0;
        minutes_q <= '0;
        seconds_q <= '0;
        alarm_q   <= 1'b0;
        idx_q     <= '0;
        for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= default_word(i % DEPTH, DDRAM_POS);
        end
`ifdef FRAME_DOUBLE_BUF_EN
        active_q  <= 1'b0;
`endif
    endtask

    assign o_rd_command = mem[rd_addr];

endmodule

// File: tb/tb_lcd_frame_builder.sv
// Directed self-checking bench for lcd_frame_builder (default and FRAME_DOUBLE_BUF_EN builds).
module tb_lcd_frame_builder;

    logic        clk;
    logic        rst_n;
    logic        update;
    logic [7:0]  hours, minutes, seconds;
    logic        alarm_on;
    logic        frame_done;
    logic [3:0]  rd_addr;
    logic [10:0] rd_command;
    logic [3:0]  addr_begin, addr_end;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cnt;

`ifdef FRAME_DOUBLE_BUF_EN
    localparam int BUSY_ONE = 13;
    localparam int BUSY_TWO = 27;
`else
    localparam int BUSY_ONE = 12;
    localparam int BUSY_TWO = 25;
`endif

    logic [10:0] dflt [11] = '{11'h080, 11'h230, 11'h230, 11'h23A, 11'h230, 11'h230,
                               11'h23A, 11'h230, 11'h230, 11'h220, 11'h220};

    lcd_frame_builder #(.WIDTH_MEM(4), .DDRAM_POS(8'h80)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_update     (update),
        .i_hours      (hours),
        .i_minutes    (minutes),
        .i_seconds    (seconds),
        .i_alarm_on   (alarm_on),
        .i_frame_done (frame_done),
        .i_rd_addr    (rd_addr),
        .o_rd_command (rd_command),
        .o_addr_begin (addr_begin),
        .o_addr_end   (addr_end),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int a, input logic [10:0] exp, input string tag);
        rd_addr = 4'(a);
        #1;
        chk($sformatf("%s_e%0d", tag, a), 32'(rd_command), 32'(exp));
    endtask

    task automatic request(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic al);
        hours    = h;
        minutes  = m;
        seconds  = s;
        alarm_on = al;
        update   = 1'b1;
        tick();
        update   = 1'b0;
    endtask

    // Counts further busy cycles until idle, bounded
    task automatic run_count(input int start, output int n);
        n = start;
        for (int k = 0; k < 80; k++) begin
            if (!busy) break;
            tick();
            if (busy) n++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        update     = 1'b0;
        hours      = 8'h00;
        minutes    = 8'h00;
        seconds    = 8'h00;
        alarm_on   = 1'b0;
        frame_done = 1'b1;
        rd_addr    = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: reset frame, unused tail reads zero, address range
        chk("reset_busy", 32'(busy), 32'd0);
        chk("addr_begin", 32'(addr_begin), 32'd0);
        chk("addr_end", 32'(addr_end), 32'd10);
        for (int i = 0; i < 11; i++) rd(i, dflt[i], "reset");
        for (int i = 11; i < 16; i++) rd(i, 11'h000, "tail");

        // 2: 12:34:56 with alarm
        tick();
        request(8'h12, 8'h34, 8'h56, 1'b1);
        chk("s2_busy_accept", 32'(busy), 32'd1);
        run_count(1, cnt);
        chk("s2_busy_len", 32'(cnt), 32'(BUSY_ONE));
        rd(0, 11'h080, "s2");
        rd(1, 11'h231, "s2");
        rd(2, 11'h232, "s2");
        rd(3, 11'h23A, "s2");
        rd(5, 11'h234, "s2");
        rd(8, 11'h236, "s2");
        rd(9, 11'h220, "s2");
        rd(10, 11'h22A, "s2");

        // 3: invalid hours digit shows '?'
        tick();
        request(8'h1F, 8'h34, 8'h56, 1'b0);
        run_count(1, cnt);
        chk("s3_busy_len", 32'(cnt), 32'(BUSY_ONE));
        rd(1, 11'h231, "s3");
        rd(2, 11'h23F, "s3");
        rd(4, 11'h233, "s3");
        rd(8, 11'h236, "s3");
        rd(10, 11'h220, "s3");

        // 4: second request mid-WRITE queues one more rebuild with no busy gap
        tick();
        request(8'h01, 8'h02, 8'h03, 1'b0);
        cnt = 1;
        repeat (3) begin
            tick();
            if (busy) cnt++;
        end
        hours    = 8'h23;
        minutes  = 8'h59;
        seconds  = 8'h59;
        alarm_on = 1'b1;
        update   = 1'b1;
        tick();
        update   = 1'b0;
        if (busy) cnt++;
        run_count(cnt, cnt);
        chk("s4_busy_len", 32'(cnt), 32'(BUSY_TWO));
        rd(1, 11'h232, "s4");
        rd(2, 11'h233, "s4");
        rd(3, 11'h23A, "s4");
        rd(4, 11'h235, "s4");
        rd(5, 11'h239, "s4");
        rd(7, 11'h235, "s4");
        rd(8, 11'h239, "s4");
        rd(10, 11'h22A, "s4");

        // 5: reset in the middle of WRITE restores the default frame at once
        tick();
        request(8'h12, 8'h34, 8'h56, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("s5_busy_rst", 32'(busy), 32'd0);
        for (int i = 0; i < 11; i++) rd(i, dflt[i], "s5");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("s5_busy_after", 32'(busy), 32'd0);
        rd(1, 11'h230, "s5_after");

`ifdef FRAME_DOUBLE_BUF_EN
        // 6: new frame stays hidden until the sequencer finishes the current one
        frame_done = 1'b0;
        tick();
        request(8'h12, 8'h34, 8'h56, 1'b1);
        repeat (20) tick();
        chk("s6_busy_hold", 32'(busy), 32'd1);
        rd(1, 11'h230, "s6_old");
        rd(10, 11'h220, "s6_old");
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("s6_busy_swap", 32'(busy), 32'd0);
        rd(1, 11'h231, "s6_new");
        rd(8, 11'h236, "s6_new");
        rd(10, 11'h22A, "s6_new");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
